uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers writes and launches one byte at a
// time, waiting for a rising edge of the transmitter's done signal between launches.
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_SysClock,
  input  logic              i_ResetN,
  input  logic              i_WrEn,
  input  logic [7:0]        i_WrByte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_TxValid,
  output logic [7:0]        o_TxByte,
  input  logic              i_TxDone,
  output logic              o_Busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [ADDR_W:0]   FullCnt = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              full_q, empty_q;
  logic              ovf_q, ovf_d;
  logic              txvalid_q, txvalid_d;
  logic [7:0]        txbyte_q, txbyte_d;
  logic              done_q;

  logic wr_acc;
  logic pop;
  logic done_rise;

  // Write acceptance looks only at the registered full flag, so a pop in the
  // same cycle cannot make room for a write that arrives while full.
  assign wr_acc    = i_WrEn && !full_q;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign done_rise = i_TxDone && !done_q;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    state_d   = state_q;
    txbyte_d  = txbyte_q;
    txvalid_d = 1'b0;
    ovf_d     = i_WrEn && full_q;

    if (wr_acc) wptr_d = wptr_q + PtrOne;

    if (pop) begin
      rptr_d    = rptr_q + PtrOne;
      txbyte_d  = mem_q[rptr_q];
      txvalid_d = 1'b1;
      state_d   = ST_WAIT;
    end else if ((state_q == ST_WAIT) && done_rise) begin
      state_d = ST_IDLE;
    end

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      txvalid_q <= 1'b0;
      txbyte_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      full_q    <= (count_d == FullCnt);
      empty_q   <= (count_d == '0);
      ovf_q     <= ovf_d;
      txvalid_q <= txvalid_d;
      txbyte_q  <= txbyte_d;
      done_q    <= i_TxDone;
    end
  end

  always_ff @(posedge i_SysClock) begin
    if (i_ResetN && wr_acc) mem_q[wptr_q] <= i_WrByte;
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_TxValid  = txvalid_q;
  assign o_TxByte   = txbyte_q;
  assign o_Busy     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based model predicts every output each
// cycle, plus literal checks on latency, fill/overflow, held done and reset.
module tb_uart_tx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              we;
  logic [7:0]        wb;
  logic              done;
  logic              full, empty, ovf, txvalid, busy;
  logic [ADDR_W:0]   count;
  logic [7:0]        txbyte;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_SysClock (clk),
    .i_ResetN   (rstn),
    .i_WrEn     (we),
    .i_WrByte   (wb),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (ovf),
    .o_TxValid  (txvalid),
    .o_TxByte   (txbyte),
    .i_TxDone   (done),
    .o_Busy     (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: stored bytes as a queue, plus transmitter-side status.
  byte unsigned mq[$];
  bit           mbusy, mprev, mvalid, movf;
  byte unsigned mbyte;

  byte unsigned in_log[$];
  byte unsigned out_log[$];
  int           tx_timer;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit w, input byte unsigned b, input bit d, input bit r);
    bit was_full, launch, rise;
    if (!r) begin
      mq.delete();
      mbusy = 0; mprev = 0; mvalid = 0; movf = 0; mbyte = 8'h00;
    end else begin
      was_full = (mq.size() == DEPTH);
      movf     = w && was_full;
      launch   = !mbusy && (mq.size() > 0);
      rise     = d && !mprev;
      if (launch) mbyte = mq.pop_front();
      mvalid = launch;
      if (w && !was_full) begin
        mq.push_back(b);
        in_log.push_back(b);
      end
      if (launch) mbusy = 1;
      else if (mbusy && rise) mbusy = 0;
      mprev = d;
    end
  endtask

  // Called at a falling edge: drive, take the rising edge, compare at the next falling edge.
  task automatic cycle(input bit w, input byte unsigned b, input bit d, input bit r);
    we = w; wb = b; done = d; rstn = r;
    @(posedge clk);
    model_edge(w, b, d, r);
    @(negedge clk);
    chk("count",    int'(count),   mq.size());
    chk("empty",    int'(empty),   int'(mq.size() == 0));
    chk("full",     int'(full),    int'(mq.size() == DEPTH));
    chk("txvalid",  int'(txvalid), int'(mvalid));
    chk("txbyte",   int'(txbyte),  int'(mbyte));
    chk("busy",     int'(busy),    int'(mbusy));
    chk("overflow", int'(ovf),     int'(movf));
    if (txvalid) out_log.push_back(txbyte);
  endtask

  // Transmitter emulation: pulses done a random number of cycles after launch.
  task automatic tcycle(input bit w, input byte unsigned b);
    bit d;
    d = 0;
    if (mbusy) begin
      if (tx_timer == 0) begin
        d = 1;
        tx_timer = $urandom_range(1, 6);
      end else begin
        tx_timer--;
      end
    end
    cycle(w, b, d, 1);
  endtask

  task automatic do_reset();
    repeat (2) cycle(0, 8'h00, 0, 0);
    in_log.delete();
    out_log.delete();
    tx_timer = 2;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((mq.size() > 0 || mbusy) && n < budget) begin
      tcycle(0, 8'h00);
      n++;
    end
    chk("drain_timeout", int'(mq.size() > 0 || mbusy), 0);
  endtask

  initial begin
    rstn = 0; we = 0; wb = 0; done = 0;
    @(negedge clk);
    do_reset();
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);

    // Single byte latency
    cycle(1, 8'hA5, 0, 1);
    chk("lat_empty", int'(empty), 0);
    chk("lat_valid_early", int'(txvalid), 0);
    cycle(0, 8'h00, 0, 1);
    chk("lat_valid", int'(txvalid), 1);
    chk("lat_byte", int'(txbyte), 8'hA5);
    cycle(0, 8'h00, 0, 1);
    chk("lat_pulse", int'(txvalid), 0);
    chk("lat_busy", int'(busy), 1);
    chk("lat_hold", int'(txbyte), 8'hA5);
    cycle(0, 8'h00, 1, 1);
    chk("lat_idle", int'(busy), 0);
    cycle(0, 8'h00, 0, 1);

    // Burst 01..05 in order
    do_reset();
    for (int i = 1; i <= 5; i++) tcycle(1, 8'(i));
    drain(500);
    chk("burst_len", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk("burst_byte", int'(out_log[i]), i + 1);

    // Fill with the transmitter stalled: 1 launched, 16 stored, 1 rejected
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(1, 8'($urandom_range(0, 255)), 0, 1);
      if (i == 16) chk("fill_count15_to16", int'(count), 16);
    end
    chk("fill_ovf", int'(ovf), 1);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    cycle(0, 8'h00, 0, 1);
    chk("fill_ovf_pulse", int'(ovf), 0);
    chk("fill_count_hold", int'(count), 16);

    // Held-high done must not end the second wait
    do_reset();
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    chk("held_launch", int'(txvalid), 1);
    chk("held_byte", int'(txbyte), 8'h22);
    repeat (4) cycle(0, 8'h00, 1, 1);
    chk("held_busy", int'(busy), 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 1, 1);
    chk("held_release", int'(busy), 0);

    // Reset while waiting with 3 bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h30 + i), 0, 1);
    chk("rw_queued", int'(count), 3);
    chk("rw_busy_pre", int'(busy), 1);
    cycle(0, 8'h00, 0, 0);
    chk("rw_empty", int'(empty), 1);
    chk("rw_busy", int'(busy), 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 8'h00, i[0], 1);
      chk("rw_no_launch", int'(txvalid), 0);
    end

    // Random writes overlapping with draining, wrapping the pointers
    do_reset();
    begin
      int n;
      n = 0;
      while ((in_log.size() < 40 || mq.size() > 0 || mbusy) && n < 3000) begin
        tcycle((in_log.size() < 40) && ($urandom_range(0, 99) < 60),
               8'($urandom_range(0, 255)));
        n++;
      end
      chk("rand_timeout", int'(n >= 3000), 0);
    end
    chk("rand_len", out_log.size(), in_log.size());
    for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
      chk("rand_order", int'(out_log[i]), int'(in_log[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
